npu_seq_ctrl: RTL
=================

Name: npu_seq_ctrl

Overview:
- Parametrised second-generation NPU sequencer. It loads per-invocation input and output word counts from the config stream, then gates input-FIFO reads and output-FIFO writes on behalf of the NPU scheduler.
- It tracks explicit FEED/DRAIN phases with stall states, and handles zero-count invocations.
- It exposes done pulses, an invocation counter and stall-cycle statistics.
- It sits between the config/input/output FIFOs and the PE scheduler.

Parameters:
- CNT_W, 16, width of input/output count registers and running counters
- CFG_W, 16, width of config data bus (CFG_W >= CNT_W; low CNT_W bits used)
- INV_W, 32, width of completed-invocation counter (wraps)
- STL_W, 16, width of saturating stall-cycle counter

Ports:
- CLK  in  1  clock
- RST  in  1  reset, synchronous, active-high
- cfg_data  in  CFG_W  config data carrying count values
- cfg_in_we  in  1  load input count (honoured only in CONFIG)
- cfg_out_we  in  1  load output count (honoured only in CONFIG)
- cfg_fifo_empty  in  1  config FIFO empty
- in_fifo_empty  in  1  input FIFO empty
- out_fifo_full  in  1  output FIFO full
- sched_rd_req  in  1  scheduler wants an input word
- sched_wr_req  in  1  scheduler has an output word
- abort  in  1  synchronous abort of the current invocation
- in_fifo_rd_en  out  1  combinational input FIFO read strobe
- out_fifo_wr_en  out  1  combinational output FIFO write strobe
- state_enc  out  3  encoded state
- st_idle, st_config, st_compute, st_stall  out  1 each  registered state flags
- inputs_done  out  1  all inputs consumed this invocation
- inv_done  out  1  one-cycle pulse on invocation completion
- inv_count  out  INV_W  completed invocations
- stall_cycles  out  STL_W  saturating count of cycles spent in stall states

Behaviour:
- Reset values:
  - state IDLE; st_idle=1, all other flags 0; state_enc=IDLE.
  - in_cnt, out_cnt, running counters, inv_count and stall_cycles = 0.
  - inv_done=0, inputs_done=0.
  - RST mid-invocation discards all progress; no strobes in the reset cycle.
- States (encoding in package): IDLE=0, CONFIG=1, FEED=2, STALL_IN=3, DRAIN=4, STALL_OUT=5.
- st_compute=1 in FEED/DRAIN/STALL_*; st_stall=1 in STALL_*; inputs_done=1 in DRAIN/STALL_OUT.
- IDLE:
  - If ~in_fifo_empty -> FEED. Compute has priority over config.
  - Else if ~cfg_fifo_empty -> CONFIG.
- CONFIG:
  - cfg_in_we loads in_cnt <= cfg_data[CNT_W-1:0]; cfg_out_we loads out_cnt likewise. Both may fire in the same cycle.
  - Go to IDLE when cfg_fifo_empty; loads in that same cycle still take effect.
  - cfg_*_we outside CONFIG is ignored.
- FEED:
  - in_fifo_rd_en = sched_rd_req & ~in_fifo_empty & (in_cur != in_cnt); in_cur increments on each read.
  - If a read makes in_cur == in_cnt, or in_cnt == 0 on entry cycle -> DRAIN next cycle, clearing in_cur.
  - Else if in_fifo_empty -> STALL_IN.
- STALL_IN: -> FEED when ~in_fifo_empty; no strobes while stalled.
- DRAIN:
  - out_fifo_wr_en = sched_wr_req & ~out_fifo_full & (out_cur != out_cnt). A write is never issued into a full FIFO.
  - A write reaching out_cnt, or out_cnt == 0 -> IDLE. On that transition: out_cur cleared, inv_done pulsed, inv_count++ (wraps at 2^INV_W).
  - Else if sched_wr_req & out_fifo_full -> STALL_OUT.
- STALL_OUT: -> DRAIN when ~out_fifo_full.
- Strobes are 0 in IDLE/CONFIG/STALL_*. Read and write are never both asserted (phases are disjoint).
- abort:
  - In any compute state -> IDLE next cycle; running counters cleared; no inv_done; in_cnt/out_cnt retained.
  - Strobes are forced 0 in the abort cycle.
  - In IDLE/CONFIG, abort is ignored.
  - RST has priority over abort.
- stall_cycles increments once per cycle in STALL_*, saturates at all-ones, and is cleared only by RST.
- Counts of 2^CNT_W-1 must be supported; running counters never wrap.

Decomposition:
- Package npu_pkg holds the state encoding localparams and the NPU_STATE_W=3 constant.
- One sub-module, npu_seq_counter: CNT_W up-counter with clear, inc and a terminal-compare output against a limit input. Instantiated twice (input and output side).

Test Plan:
- Config in_cnt=3, out_cnt=2, then 3 input words with sched_rd_req=1 -> exactly 3 rd_en pulses, FEED->DRAIN. Then 2 wr_en pulses, inv_done 1 cycle, inv_count=1, back to IDLE.
- Input FIFO empties after word 1 of 3 -> STALL_IN, st_stall=1, stall_cycles counts 4 over 4 empty cycles. Refill -> FEED, remaining 2 reads, total rd_en=3.
- out_fifo_full held during DRAIN with sched_wr_req=1 -> out_fifo_wr_en never 1 while full, STALL_OUT entered. Release -> writes resume, out_cur ends at out_cnt.
- in_cnt=0, out_cnt=0, input FIFO non-empty -> IDLE->FEED->DRAIN->IDLE, zero strobes, inv_done pulses once.
- abort asserted in FEED after 1 of 3 reads -> IDLE next cycle, no inv_done, inv_count unchanged. Next invocation reads a full 3 words.
- Both cfg_in_we and cfg_out_we with cfg_data=0x0005 while cfg_fifo_empty=1 -> both counts=5, CONFIG->IDLE. cfg_in_we in IDLE -> in_cnt unchanged. RST during DRAIN -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/npu_pkg.sv
// Shared definitions for the NPU sequencer: state encoding and state-class helpers.
package npu_pkg;

   localparam int NPU_STATE_W = 3;

   typedef logic [NPU_STATE_W-1:0] npu_state_t;

   localparam npu_state_t ST_IDLE      = 3'd0;
   localparam npu_state_t ST_CONFIG    = 3'd1;
   localparam npu_state_t ST_FEED      = 3'd2;
   localparam npu_state_t ST_STALL_IN  = 3'd3;
   localparam npu_state_t ST_DRAIN     = 3'd4;
   localparam npu_state_t ST_STALL_OUT = 3'd5;

   function automatic logic is_compute(input npu_state_t s);
      return (s == ST_FEED) || (s == ST_STALL_IN) || (s == ST_DRAIN) || (s == ST_STALL_OUT);
   endfunction

   function automatic logic is_stall(input npu_state_t s);
      return (s == ST_STALL_IN) || (s == ST_STALL_OUT);
   endfunction

endpackage

// File: rtl/npu_seq_counter.sv
// Running word counter for one side of an invocation; stops at its limit so it never wraps.
module npu_seq_counter #(
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             clr,
   input  logic             inc,
   input  logic [CNT_W-1:0] limit,
   output logic [CNT_W-1:0] count,
   output logic             at_limit
);

   localparam logic [CNT_W-1:0] ONE = 1;

   assign at_limit = (count == limit);

   always_ff @(posedge CLK) begin
      if (RST || clr)
         count <= '0;
      else if (inc && !at_limit)
         count <= count + ONE;
   end

endmodule

// File: rtl/npu_seq_ctrl.sv
// NPU sequencer: loads per-invocation word counts, then gates input reads (FEED)
// and output writes (DRAIN) for the scheduler, with stall tracking and statistics.
module npu_seq_ctrl
   import npu_pkg::*;
#(
   parameter int CNT_W = 16,
   parameter int CFG_W = 16,
   parameter int INV_W = 32,
   parameter int STL_W = 16
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic [CFG_W-1:0]       cfg_data,
   input  logic                   cfg_in_we,
   input  logic                   cfg_out_we,
   input  logic                   cfg_fifo_empty,
   input  logic                   in_fifo_empty,
   input  logic                   out_fifo_full,
   input  logic                   sched_rd_req,
   input  logic                   sched_wr_req,
   input  logic                   abort,
   output logic                   in_fifo_rd_en,
   output logic                   out_fifo_wr_en,
   output logic [NPU_STATE_W-1:0] state_enc,
   output logic                   st_idle,
   output logic                   st_config,
   output logic                   st_compute,
   output logic                   st_stall,
   output logic                   inputs_done,
   output logic                   inv_done,
   output logic [INV_W-1:0]       inv_count,
   output logic [STL_W-1:0]       stall_cycles
);

   localparam logic [CNT_W:0]   CNT_ONE = 1;
   localparam logic [INV_W-1:0] INV_ONE = 1;
   localparam logic [STL_W-1:0] STL_ONE = 1;

   npu_state_t       state, nxt;
   logic [CNT_W-1:0] in_cnt, out_cnt, in_cur, out_cur;
   logic             in_term, out_term, in_last, out_last;
   logic             abort_c, feed_done, drain_done, in_clr, out_clr;

   generate
      if (CFG_W > CNT_W) begin : g_cfg_hi
         logic unused_cfg_hi;
         assign unused_cfg_hi = ^cfg_data[CFG_W-1:CNT_W];
      end
   endgenerate

   // Widened compare so a limit of all-ones cannot alias through wrap-around.
   assign in_last  = (({1'b0, in_cur}  + CNT_ONE) == {1'b0, in_cnt});
   assign out_last = (({1'b0, out_cur} + CNT_ONE) == {1'b0, out_cnt});

   assign abort_c    = abort && is_compute(state);
   assign feed_done  = (state == ST_FEED)  && !abort && ((in_fifo_rd_en  && in_last)  || in_term);
   assign drain_done = (state == ST_DRAIN) && !abort && ((out_fifo_wr_en && out_last) || out_term);
   assign in_clr     = abort_c || feed_done;
   assign out_clr    = abort_c || drain_done;

   npu_seq_counter #(.CNT_W(CNT_W)) u_in_ctr (
      .CLK      (CLK),
      .RST      (RST),
      .clr      (in_clr),
      .inc      (in_fifo_rd_en),
      .limit    (in_cnt),
      .count    (in_cur),
      .at_limit (in_term)
   );

   npu_seq_counter #(.CNT_W(CNT_W)) u_out_ctr (
      .CLK      (CLK),
      .RST      (RST),
      .clr      (out_clr),
      .inc      (out_fifo_wr_en),
      .limit    (out_cnt),
      .count    (out_cur),
      .at_limit (out_term)
   );

   // State register; flags are flopped from the next state so they track state exactly.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= ST_IDLE;
         st_idle    <= 1'b1;
         st_config  <= 1'b0;
         st_compute <= 1'b0;
         st_stall   <= 1'b0;
      end else begin
         state      <= nxt;
         st_idle    <= (nxt == ST_IDLE);
         st_config  <= (nxt == ST_CONFIG);
         st_compute <= is_compute(nxt);
         st_stall   <= is_stall(nxt);
      end
   end

   always_comb begin
      nxt = state;
      if (abort_c)
         nxt = ST_IDLE;
      else begin
         case (state)
            ST_IDLE: begin
               if (!in_fifo_empty)       nxt = ST_FEED;
               else if (!cfg_fifo_empty) nxt = ST_CONFIG;
            end
            ST_CONFIG:    if (cfg_fifo_empty) nxt = ST_IDLE;
            ST_FEED: begin
               if (feed_done)          nxt = ST_DRAIN;
               else if (in_fifo_empty) nxt = ST_STALL_IN;
            end
            ST_STALL_IN:  if (!in_fifo_empty) nxt = ST_FEED;
            ST_DRAIN: begin
               if (drain_done)                         nxt = ST_IDLE;
               else if (sched_wr_req && out_fifo_full) nxt = ST_STALL_OUT;
            end
            ST_STALL_OUT: if (!out_fifo_full) nxt = ST_DRAIN;
            default:      nxt = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      in_fifo_rd_en  = 1'b0;
      out_fifo_wr_en = 1'b0;
      if (!RST && !abort) begin
         if (state == ST_FEED)
            in_fifo_rd_en = sched_rd_req && !in_fifo_empty && !in_term;
         if (state == ST_DRAIN)
            out_fifo_wr_en = sched_wr_req && !out_fifo_full && !out_term;
      end
   end

   assign state_enc   = state;
   assign inputs_done = (state == ST_DRAIN) || (state == ST_STALL_OUT);

   always_ff @(posedge CLK) begin
      if (RST) begin
         in_cnt  <= '0;
         out_cnt <= '0;
      end else if (state == ST_CONFIG) begin
         if (cfg_in_we)  in_cnt  <= cfg_data[CNT_W-1:0];
         if (cfg_out_we) out_cnt <= cfg_data[CNT_W-1:0];
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         inv_done     <= 1'b0;
         inv_count    <= '0;
         stall_cycles <= '0;
      end else begin
         inv_done <= drain_done;
         if (drain_done)
            inv_count <= inv_count + INV_ONE;
         if (is_stall(state) && (stall_cycles != '1))
            stall_cycles <= stall_cycles + STL_ONE;
      end
   end

endmodule
